// File: rtl/setup_pkg.sv
// setup_pkg: shared definitions for the time-setup controller.
//   - field_sel encodings (FIELD_HOUR, FIELD_MIN, FIELD_SEC)
//   - ready FSM and button repeat FSM state types
//   - default timing constants (cycles of a 125 MHz-class clock)
//   - wrap_step(): one wrapping increment/decrement of a bounded field
package setup_pkg;

    localparam logic [1:0] FIELD_HOUR = 2'd0;
    localparam logic [1:0] FIELD_MIN  = 2'd1;
    localparam logic [1:0] FIELD_SEC  = 2'd2;

    localparam int unsigned DefReadyHold   = 62500000;
    localparam int unsigned DefRepeatDelay = 31250000;
    localparam int unsigned DefRepeatRate  = 12500000;

    typedef enum logic [1:0] {
        RdyIdle,
        RdyHold,
        RdyWaitRel
    } ready_state_e;

    typedef enum logic [1:0] {
        RepIdle,
        RepDelay,
        RepRepeat
    } repeat_state_e;

    // Up: max wraps to 0. Down: 0 wraps to max.
    function automatic logic [6:0] wrap_step(input logic [6:0] val,
                                             input logic [6:0] max_val,
                                             input logic       up);
        if (up) begin
            return (val >= max_val) ? 7'd0 : val + 7'd1;
        end
        return (val == 7'd0) ? max_val : val - 7'd1;
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// btn_repeat: press detection and auto-repeat for one level button.
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   btn        raw button level
//   force_idle abort any repeat and ignore presses this cycle
//   step       1-cycle pulse: press step or repeat step
module btn_repeat
    import setup_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = DefRepeatDelay,
    parameter int unsigned REPEAT_RATE  = DefRepeatRate
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic force_idle,
    output logic step
);

    localparam int unsigned CntMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CntW   = $clog2(CntMax);
    localparam logic [CntW-1:0] DelayLast = CntW'(REPEAT_DELAY - 1);
    localparam logic [CntW-1:0] RateLast  = CntW'(REPEAT_RATE - 1);

    logic            btn_q, btn_prev_q;
    // Set once the raw button has been seen low after reset, so a button
    // held through reset release never counts as a press.
    logic            armed_q;
    repeat_state_e   state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            press;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q      <= 1'b0;
            btn_prev_q <= 1'b0;
            armed_q    <= 1'b0;
            state_q    <= RepIdle;
            cnt_q      <= '0;
        end else begin
            btn_q      <= btn;
            btn_prev_q <= btn_q;
            armed_q    <= armed_q | ~btn;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
        end
    end

    assign press = btn_q & ~btn_prev_q & armed_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step    = 1'b0;
        if (force_idle) begin
            state_d = RepIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RepIdle: begin
                    if (press) begin
                        step    = 1'b1;
                        state_d = RepDelay;
                        cnt_d   = '0;
                    end
                end
                RepDelay: begin
                    if (!btn_q) begin
                        state_d = RepIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == DelayLast) begin
                        step    = 1'b1;
                        state_d = RepRepeat;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                RepRepeat: begin
                    if (!btn_q) begin
                        state_d = RepIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == RateLast) begin
                        step  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_d = RepIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/setup_ctrl.sv
// setup_ctrl: button-driven hour/minute/second setup with a commit pulse.
// Ports:
//   clk, reset          system clock; synchronous active-high reset
//   start               level request to commit; yields one setup_ready pulse
//   btn_inc, btn_dec    step the selected field (with auto-repeat)
//   btn_sel             advance field_sel 0->1->2->0 (no repeat)
//   setup_hour/minute/second  field values, each bounded by its MAX
//   field_sel           0 = hour, 1 = minute, 2 = second
//   setup_ready         high for READY_HOLD cycles per start request
module setup_ctrl
    import setup_pkg::*;
#(
    parameter int unsigned READY_HOLD   = DefReadyHold,
    parameter int unsigned REPEAT_DELAY = DefRepeatDelay,
    parameter int unsigned REPEAT_RATE  = DefRepeatRate,
    parameter int unsigned HOUR_MAX     = 23,
    parameter int unsigned MIN_MAX      = 59,
    parameter int unsigned SEC_MAX      = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_sel,
    output logic [6:0] setup_hour,
    output logic [6:0] setup_minute,
    output logic [6:0] setup_second,
    output logic [1:0] field_sel,
    output logic       setup_ready
);

    localparam int unsigned HoldW = $clog2(READY_HOLD + 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(READY_HOLD - 1);

    ready_state_e     rdy_q, rdy_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic             start_armed_q;
    logic             sel_q, sel_prev_q, sel_armed_q;
    logic [6:0]       hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic [1:0]       field_q, field_d;
    logic             in_hold, inc_step, dec_step, step_up, step_dn, sel_press;

    assign in_hold = (rdy_q == RdyHold);

    btn_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_inc (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn_inc),
        .force_idle (in_hold),
        .step       (inc_step)
    );

    btn_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_dec (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn_dec),
        .force_idle (in_hold),
        .step       (dec_step)
    );

    // Simultaneous inc and dec requests cancel each other.
    assign step_up   = inc_step & ~dec_step & ~in_hold;
    assign step_dn   = dec_step & ~inc_step & ~in_hold;
    assign sel_press = sel_q & ~sel_prev_q & sel_armed_q & ~in_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_q         <= RdyIdle;
            hold_cnt_q    <= '0;
            start_armed_q <= 1'b0;
            sel_q         <= 1'b0;
            sel_prev_q    <= 1'b0;
            sel_armed_q   <= 1'b0;
            hour_q        <= '0;
            min_q         <= '0;
            sec_q         <= '0;
            field_q       <= FIELD_HOUR;
        end else begin
            rdy_q         <= rdy_d;
            hold_cnt_q    <= hold_cnt_d;
            start_armed_q <= start_armed_q | ~start;
            sel_q         <= btn_sel;
            sel_prev_q    <= sel_q;
            sel_armed_q   <= sel_armed_q | ~btn_sel;
            hour_q        <= hour_d;
            min_q         <= min_d;
            sec_q         <= sec_d;
            field_q       <= field_d;
        end
    end

    // Fields: the step uses the field selected before any select advance.
    always_comb begin
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        field_d = field_q;
        if (step_up || step_dn) begin
            case (field_q)
                FIELD_HOUR: hour_d = wrap_step(hour_q, 7'(HOUR_MAX), step_up);
                FIELD_MIN:  min_d  = wrap_step(min_q, 7'(MIN_MAX), step_up);
                FIELD_SEC:  sec_d  = wrap_step(sec_q, 7'(SEC_MAX), step_up);
                default:    ;
            endcase
        end
        if (sel_press) begin
            field_d = (field_q == FIELD_SEC) ? FIELD_HOUR : field_q + 2'd1;
        end
    end

    always_comb begin
        rdy_d      = rdy_q;
        hold_cnt_d = hold_cnt_q;
        case (rdy_q)
            RdyIdle: begin
                if (start && start_armed_q) begin
                    rdy_d      = RdyHold;
                    hold_cnt_d = '0;
                end
            end
            RdyHold: begin
                if (hold_cnt_q == HoldLast) begin
                    rdy_d      = start ? RdyWaitRel : RdyIdle;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HoldW'(1);
                end
            end
            RdyWaitRel: begin
                if (!start) rdy_d = RdyIdle;
            end
            default: rdy_d = RdyIdle;
        endcase
    end

    assign setup_hour   = hour_q;
    assign setup_minute = min_q;
    assign setup_second = sec_q;
    assign field_sel    = field_q;
    assign setup_ready  = in_hold;

endmodule
